// File: rtl/store_checker.sv
// store_checker: bus-write checker for CPU simulation and on-board self-test.
// It holds an ordered list of expected (address, data) stores, watches the
// core's data-memory write port, and reports pass once every expected store
// has been seen in order, or fail on the first out-of-order/wrong store.
// Writes to one configurable scratch address can be excluded from checking.
//
// Optional feature: define STORE_CHECK_TIMEOUT_EN to enable an idle-cycle
// timeout in RUN (fail code 2). Without it RUN waits indefinitely.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   load_valid/addr/data     append one expected store (LOAD state only)
//   start                    begin checking (LOAD state only)
//   memwrite/dataadr/writedata  core write port being observed
//   busy                     checking in progress (RUN)
//   done/pass/fail           terminal status (sticky until rst)
//   fail_code                0 none, 1 mismatch, 2 timeout, 3 load overflow
//   match_cnt                expected stores matched so far
//   fail_addr/fail_data      offending write on a mismatch
module store_checker #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       DEPTH       = 8,
  parameter logic [ADDR_W-1:0] IGNORE_ADDR = ADDR_W'(80),
  parameter bit                IGNORE_ON   = 1'b1,
  parameter int unsigned       TIMEOUT     = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_valid,
  input  logic [ADDR_W-1:0]        load_addr,
  input  logic [DATA_W-1:0]        load_data,
  input  logic                     start,
  input  logic                     memwrite,
  input  logic [ADDR_W-1:0]        dataadr,
  input  logic [DATA_W-1:0]        writedata,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic [1:0]               fail_code,
  output logic [$clog2(DEPTH):0]   match_cnt,
  output logic [ADDR_W-1:0]        fail_addr,
  output logic [DATA_W-1:0]        fail_data
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] CODE_NONE     = 2'd0;
  localparam logic [1:0] CODE_MISMATCH = 2'd1;
  localparam logic [1:0] CODE_TIMEOUT  = 2'd2;
  localparam logic [1:0] CODE_OVERFLOW = 2'd3;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  // Expected-store list storage and bookkeeping
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PW-1:0]     tail_ptr;
  logic [PW-1:0]     head_ptr;
  logic [CW-1:0]     count_q;
  logic              ovf_q;

  // Registered-output next values
  logic              busy_d;
  logic              done_d;
  logic              pass_d;
  logic              fail_d;
  logic [1:0]        fail_code_d;
  logic [ADDR_W-1:0] fail_addr_d;
  logic [DATA_W-1:0] fail_data_d;

  // Event decode
  logic          load_acc;
  logic          load_drop;
  logic          ovf_eff;
  logic [CW-1:0] count_eff;
  logic          head_hit;
  logic          wr_match;
  logic          wr_skip;
  logic          wr_bad;
  logic          last_match;
  logic          timeout_hit;

  // Load handling: accept until full, then drop and flag overflow
  assign load_acc  = (state_q == S_LOAD) && load_valid && (count_q != CW'(DEPTH));
  assign load_drop = (state_q == S_LOAD) && load_valid && (count_q == CW'(DEPTH));

  // A load in the same cycle as start is counted before the start decision
  assign ovf_eff   = ovf_q || load_drop;
  assign count_eff = CW'(count_q + CW'(load_acc));

  // Write classification in RUN; a head match beats the scratch-address skip
  assign head_hit   = (dataadr == addr_mem[head_ptr]) && (writedata == data_mem[head_ptr]);
  assign wr_match   = (state_q == S_RUN) && memwrite && head_hit;
  assign wr_skip    = IGNORE_ON && (dataadr == IGNORE_ADDR);
  assign wr_bad     = (state_q == S_RUN) && memwrite && !head_hit && !wr_skip;
  assign last_match = wr_match && (CW'(match_cnt + CW'(1)) == count_q);

`ifdef STORE_CHECK_TIMEOUT_EN
  localparam int unsigned IW = $clog2(TIMEOUT + 1);

  logic [IW-1:0] idle_q;

  // Idle counter: cleared in LOAD (so it starts at 0 on entry to RUN) and on
  // every match; the timeout fires on the cycle it would reach TIMEOUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q <= '0;
    end else if (state_q == S_LOAD) begin
      idle_q <= '0;
    end else if (state_q == S_RUN) begin
      if (wr_match) begin
        idle_q <= '0;
      end else begin
        idle_q <= IW'(idle_q + IW'(1));
      end
    end
  end

  assign timeout_hit = (state_q == S_RUN) && !wr_match && (idle_q == IW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; mismatch takes priority over timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD: begin
        if (start) begin
          if (ovf_eff) begin
            state_d = S_FAIL;
          end else if (count_eff == '0) begin
            state_d = S_PASS;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (last_match) begin
          state_d = S_PASS;
        end else if (wr_bad || timeout_hit) begin
          state_d = S_FAIL;
        end
      end
      default: state_d = state_q;
    endcase
  end

  // Output next-value logic; fail_* only change on the transition into FAIL
  always_comb begin
    busy_d      = (state_d == S_RUN);
    done_d      = (state_d == S_PASS) || (state_d == S_FAIL);
    pass_d      = (state_d == S_PASS);
    fail_d      = (state_d == S_FAIL);
    fail_code_d = fail_code;
    fail_addr_d = fail_addr;
    fail_data_d = fail_data;
    if ((state_q == S_LOAD) && start && ovf_eff) begin
      fail_code_d = CODE_OVERFLOW;
    end else if (wr_bad) begin
      fail_code_d = CODE_MISMATCH;
      fail_addr_d = dataadr;
      fail_data_d = writedata;
    end else if (timeout_hit) begin
      fail_code_d = CODE_TIMEOUT;
      fail_addr_d = '0;
      fail_data_d = '0;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_code <= CODE_NONE;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      fail      <= fail_d;
      fail_code <= fail_code_d;
      fail_addr <= fail_addr_d;
      fail_data <= fail_data_d;
    end
  end

  // List pointers, count, overflow flag and match counter
  always_ff @(posedge clk) begin
    if (rst) begin
      tail_ptr  <= '0;
      head_ptr  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      match_cnt <= '0;
    end else begin
      if (load_acc) begin
        tail_ptr <= PW'(tail_ptr + PW'(1));
        count_q  <= CW'(count_q + CW'(1));
      end
      if (load_drop) begin
        ovf_q <= 1'b1;
      end
      if ((state_q == S_LOAD) && start) begin
        head_ptr  <= '0;
        match_cnt <= '0;
      end
      if (wr_match) begin
        head_ptr  <= PW'(head_ptr + PW'(1));
        match_cnt <= CW'(match_cnt + CW'(1));
      end
    end
  end

  // List storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (load_acc) begin
      addr_mem[tail_ptr] <= load_addr;
      data_mem[tail_ptr] <= load_data;
    end
  end

endmodule

// File: tb/tb_store_checker.sv
module tb_store_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        start;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;

  logic        busy, done, pass, fail;
  logic [1:0]  fail_code;
  logic [2:0]  match_cnt;
  logic [31:0] fail_addr, fail_data;

  logic        busy2, done2, pass2, fail2;
  logic [1:0]  fail_code2;
  logic [2:0]  match_cnt2;
  logic [31:0] fail_addr2, fail_data2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  store_checker #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(4),
    .IGNORE_ADDR(32'd80), .IGNORE_ON(1'b1), .TIMEOUT(20)
  ) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
    .start(start), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .busy(busy), .done(done), .pass(pass), .fail(fail),
    .fail_code(fail_code), .match_cnt(match_cnt),
    .fail_addr(fail_addr), .fail_data(fail_data)
  );

  store_checker #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(4),
    .IGNORE_ADDR(32'd80), .IGNORE_ON(1'b0), .TIMEOUT(20)
  ) dut_noign (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
    .start(start), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .busy(busy2), .done(done2), .pass(pass2), .fail(fail2),
    .fail_code(fail_code2), .match_cnt(match_cnt2),
    .fail_addr(fail_addr2), .fail_data(fail_data2)
  );

  typedef struct {
    logic        rst;
    logic        lv;
    logic [31:0] la;
    logic [31:0] ld;
    logic        st;
    logic        mw;
    logic [31:0] da;
    logic [31:0] wd;
    logic [3:0]  flags;   // {busy, done, pass, fail}
    logic [1:0]  code;
    logic [2:0]  cnt;
    logic [31:0] fa;
    logic [31:0] fd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic lv, logic [31:0] la, logic [31:0] ld,
                              logic st, logic mw, logic [31:0] da, logic [31:0] wd,
                              logic [3:0] fl, logic [1:0] code, logic [2:0] cnt,
                              logic [31:0] fa, logic [31:0] fd);
    vec_t v;
    v.rst = r; v.lv = lv; v.la = la; v.ld = ld; v.st = st;
    v.mw = mw; v.da = da; v.wd = wd;
    v.flags = fl; v.code = code; v.cnt = cnt; v.fa = fa; v.fd = fd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; return 1 ns after the rising edge
  task automatic drive(input logic r, input logic lv, input logic [31:0] la,
                       input logic [31:0] ld, input logic st, input logic mw,
                       input logic [31:0] da, input logic [31:0] wd);
    @(negedge clk);
    rst = r; load_valid = lv; load_addr = la; load_data = ld;
    start = st; memwrite = mw; dataadr = da; writedata = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b1; load_valid = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;

    // Basic pass; memwrite ignored in LOAD; scratch write skipped in RUN
    vecs.push_back(mk(1,0,  0,0,0,0,  0,0, 4'b0000,0,0,  0,0));
    vecs.push_back(mk(0,1, 84,7,0,1,  1,1, 4'b0000,0,0,  0,0));
    vecs.push_back(mk(0,0,  0,0,1,0,  0,0, 4'b1000,0,0,  0,0));
    vecs.push_back(mk(0,0,  0,0,0,1, 80,3, 4'b1000,0,0,  0,0));
    vecs.push_back(mk(0,0,  0,0,0,1, 84,7, 4'b0110,0,1,  0,0));
    vecs.push_back(mk(0,1,  9,9,1,1,  5,5, 4'b0110,0,1,  0,0));
    // Mismatch after one match, back-to-back writes; fail_* hold afterwards
    vecs.push_back(mk(1,0,  0,0,0,0,  0,0, 4'b0000,0,0,  0,0));
    vecs.push_back(mk(0,1, 84,7,0,0,  0,0, 4'b0000,0,0,  0,0));
    vecs.push_back(mk(0,1, 88,9,0,0,  0,0, 4'b0000,0,0,  0,0));
    vecs.push_back(mk(0,0,  0,0,1,0,  0,0, 4'b1000,0,0,  0,0));
    vecs.push_back(mk(0,0,  0,0,0,1, 84,7, 4'b1000,0,1,  0,0));
    vecs.push_back(mk(0,0,  0,0,0,1, 88,5, 4'b0101,1,1, 88,5));
    vecs.push_back(mk(0,0,  0,0,0,1, 84,7, 4'b0101,1,1, 88,5));
    // Overflow: five loads into a 4-deep list
    vecs.push_back(mk(1,0,  0,0,0,0,  0,0, 4'b0000,0,0,  0,0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0,1, 32'(100 + 4*i), 32'(i),0,0, 0,0, 4'b0000,0,0, 0,0));
    vecs.push_back(mk(0,0,  0,0,1,0,  0,0, 4'b0101,3,0,  0,0));
    // Empty list passes immediately
    vecs.push_back(mk(1,0,  0,0,0,0,  0,0, 4'b0000,0,0,  0,0));
    vecs.push_back(mk(0,0,  0,0,1,0,  0,0, 4'b0110,0,0,  0,0));
    // Head entry at the scratch address: wrong data skipped, exact match counts
    vecs.push_back(mk(1,0,  0,0,0,0,  0,0, 4'b0000,0,0,  0,0));
    vecs.push_back(mk(0,1, 80,5,1,0,  0,0, 4'b1000,0,0,  0,0));
    vecs.push_back(mk(0,0,  0,0,0,1, 80,6, 4'b1000,0,0,  0,0));
    vecs.push_back(mk(0,0,  0,0,0,1, 80,5, 4'b0110,0,1,  0,0));
    // Full-width data compare: MSB difference is a mismatch
    vecs.push_back(mk(1,0,  0,0,0,0,  0,0, 4'b0000,0,0,  0,0));
    vecs.push_back(mk(0,1, 84,7,1,0,  0,0, 4'b1000,0,0,  0,0));
    vecs.push_back(mk(0,0,  0,0,0,1, 84,32'h8000_0007, 4'b0101,1,0, 84,32'h8000_0007));
    // Exactly DEPTH entries (last load with start), four back-to-back matches
    vecs.push_back(mk(1,0,  0,0,0,0,  0,0, 4'b0000,0,0,  0,0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0,1, 32'(200 + 4*i), 32'(i+1),0,0, 0,0, 4'b0000,0,0, 0,0));
    vecs.push_back(mk(0,1,212,4,1,0,  0,0, 4'b1000,0,0,  0,0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0,0, 0,0,0,1, 32'(200 + 4*i), 32'(i+1), 4'b1000,0,3'(i+1), 0,0));
    vecs.push_back(mk(0,0,  0,0,0,1,212,4, 4'b0110,0,4,  0,0));
    // Fifth load dropped in the same cycle as start still overflows
    vecs.push_back(mk(1,0,  0,0,0,0,  0,0, 4'b0000,0,0,  0,0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0,1, 32'(300 + 4*i), 32'(i),0,0, 0,0, 4'b0000,0,0, 0,0));
    vecs.push_back(mk(0,1,400,1,1,0,  0,0, 4'b0101,3,0,  0,0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].lv, vecs[i].la, vecs[i].ld,
            vecs[i].st, vecs[i].mw, vecs[i].da, vecs[i].wd);
      check($sformatf("vec%0d flags", i), 32'({busy, done, pass, fail}), 32'(vecs[i].flags));
      check($sformatf("vec%0d fail_code", i), 32'(fail_code), 32'(vecs[i].code));
      check($sformatf("vec%0d match_cnt", i), 32'(match_cnt), 32'(vecs[i].cnt));
      check($sformatf("vec%0d fail_addr", i), fail_addr, vecs[i].fa);
      check($sformatf("vec%0d fail_data", i), fail_data, vecs[i].fd);
    end

    // Scratch address checked when the skip is disabled
    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b0, 1'b1, 32'd84, 32'd7, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd80, 32'd3);
    check("noign fail", 32'(fail2), 32'd1);
    check("noign fail_code", 32'(fail_code2), 32'd1);
    check("noign fail_addr", fail_addr2, 32'd80);
    check("noign fail_data", fail_data2, 32'd3);
    check("ign still busy", 32'(busy), 32'd1);

    // Reset mid-run, then a fresh single-entry list passes
    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b0, 1'b1, 32'd84, 32'd7, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b0, 1'b1, 32'd88, 32'd9, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd84, 32'd7);
    check("midrun match_cnt", 32'(match_cnt), 32'd1);
    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd88, 32'd9);
    check("midrun rst outputs",
          32'({busy, done, pass, fail, fail_code, match_cnt}), 32'd0);
    check("midrun rst fail_addr", fail_addr, 32'd0);
    drive(1'b0, 1'b1, 32'd92, 32'd2, 1'b1, 1'b0, 32'd0, 32'd0);
    check("midrun restart busy", 32'(busy), 32'd1);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd92, 32'd2);
    check("midrun new pass", 32'({busy, done, pass, fail}), 32'b0110);
    check("midrun new match_cnt", 32'(match_cnt), 32'd1);

    // Idle behaviour in RUN with no writes
    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b0, 1'b1, 32'd84, 32'd7, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0);
    check("idle busy rises", 32'(busy), 32'd1);
`ifdef STORE_CHECK_TIMEOUT_EN
    begin
      int k = 0;
      for (int c = 1; c <= 40; c++) begin
        idle_cycle();
        if (fail) begin
          k = c;
          break;
        end
      end
      check("timeout cycles", 32'(k), 32'd20);
      check("timeout fail_code", 32'(fail_code), 32'd2);
      check("timeout fail_addr", fail_addr, 32'd0);
      check("timeout flags", 32'({busy, done, pass, fail}), 32'b0101);
    end
`else
    for (int c = 0; c < 40; c++) idle_cycle();
    check("no timeout busy", 32'({busy, done, pass, fail}), 32'b1000);
    check("no timeout fail_code", 32'(fail_code), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
